// File: rtl/mem_arbiter_if.sv
// Signal bundle shared by the fetch port, the load/store port, mem_arbiter and mem_system.
// slave = arbiter side; master = requesters plus mem_system side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] i_Addr;
    logic              i_Rd;
    logic [DATA_W-1:0] i_DataOut;
    logic              i_Done;
    logic              i_Stall;

    logic [ADDR_W-1:0] d_Addr;
    logic [DATA_W-1:0] d_DataIn;
    logic              d_Rd;
    logic              d_Wr;
    logic [DATA_W-1:0] d_DataOut;
    logic              d_Done;
    logic              d_Stall;

    logic [ADDR_W-1:0] m_Addr;
    logic [DATA_W-1:0] m_DataIn;
    logic              m_Rd;
    logic              m_Wr;
    logic [DATA_W-1:0] m_DataOut;
    logic              m_Done;
    logic              m_err;
    logic              err;

    modport slave (
        input  i_Addr, i_Rd, d_Addr, d_DataIn, d_Rd, d_Wr, m_DataOut, m_Done, m_err,
        output i_DataOut, i_Done, i_Stall, d_DataOut, d_Done, d_Stall,
               m_Addr, m_DataIn, m_Rd, m_Wr, err
    );

    modport master (
        output i_Addr, i_Rd, d_Addr, d_DataIn, d_Rd, d_Wr, m_DataOut, m_Done, m_err,
        input  i_DataOut, i_Done, i_Stall, d_DataOut, d_Done, d_Stall,
               m_Addr, m_DataIn, m_Rd, m_Wr, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates fetch (i_*) and load/store (d_*) onto one mem_system port, holding the winner until Done or timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority with D over I.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_rst_q;
    logic              r_grant_d;
    logic              r_rd;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_count;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_d_ill;
    logic              w_arb_ok;
    logic              w_grant;
    logic              w_win_d;
    logic              w_timeout;
    logic              w_finish;
    logic [DATA_W-1:0] w_rdata;

    assign w_i_req  = bus.i_Rd;
    assign w_d_req  = bus.d_Rd ^ bus.d_Wr;
    assign w_d_ill  = bus.d_Rd & bus.d_Wr;
    // The cycle right after reset is kept quiet: no grants, all outputs low.
    assign w_arb_ok = (r_state == S_IDLE) && !r_rst_q;
    assign w_grant  = w_arb_ok && (w_i_req || w_d_req);

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_d;

    assign w_win_d = w_d_req && (!w_i_req || !r_last_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d <= 1'b0;
        end else if (w_grant) begin
            r_last_d <= w_win_d;
        end
    end
`else
    assign w_win_d = w_d_req;
`endif

    // m_Done in the last allowed cycle beats the timeout.
    assign w_timeout = (r_state == S_BUSY) && !bus.m_Done && (r_count == CNT_LAST);
    assign w_finish  = (r_state == S_BUSY) && (bus.m_Done || w_timeout);
    assign w_rdata   = (bus.m_Done && r_rd) ? bus.m_DataOut : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant)  w_next = S_BUSY;
            S_BUSY:  if (w_finish) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        r_rst_q <= rst;
        if (rst) begin
            r_grant_d <= 1'b1;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_count   <= '0;
        end else if (w_grant) begin
            r_grant_d <= w_win_d;
            r_rd      <= w_win_d ? bus.d_Rd : 1'b1;
            r_wr      <= w_win_d && bus.d_Wr;
            r_count   <= '0;
        end else if ((r_state == S_BUSY) && !bus.m_Done) begin
            r_count   <= r_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_addr <= w_win_d ? bus.d_Addr : bus.i_Addr;
            r_data <= w_win_d ? bus.d_DataIn : '0;
        end
    end

    always_comb begin
        bus.i_Done    = 1'b0;
        bus.d_Done    = 1'b0;
        bus.i_DataOut = '0;
        bus.d_DataOut = '0;
        bus.m_Rd      = 1'b0;
        bus.m_Wr      = 1'b0;
        bus.m_Addr    = '0;
        bus.m_DataIn  = '0;
        if (r_state == S_BUSY) begin
            bus.m_Rd     = r_rd;
            bus.m_Wr     = r_wr;
            bus.m_Addr   = r_addr;
            bus.m_DataIn = r_data;
            if (w_finish) begin
                if (r_grant_d) begin
                    bus.d_Done    = 1'b1;
                    bus.d_DataOut = w_rdata;
                end else begin
                    bus.i_Done    = 1'b1;
                    bus.i_DataOut = w_rdata;
                end
            end
        end
        bus.i_Stall = !r_rst_q && bus.i_Rd && !(w_finish && !r_grant_d);
        bus.d_Stall = !r_rst_q && (bus.d_Rd || bus.d_Wr) && !(w_finish && r_grant_d);
        bus.err     = !r_rst_q && (w_timeout || (w_arb_ok && w_d_ill) || bus.m_err);
    end
endmodule
